// File: rtl/bypass_arb_pkg.sv
// Shared types and constants for the bypass register-port arbiter.
package bypass_arb_pkg;

  // Transaction sequencer states: grant in IDLE, then one cycle each of
  // port enable, register-file busy window, and response capture.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT    = 2'd2,
    ST_CAPTURE = 2'd3
  } arb_state_t;

  localparam int DEF_N_REQ       = 2;
  localparam int DEF_DATA_W      = 512;
  localparam int DEF_IDX_W       = 6;
  localparam int DEF_ADDR_W      = 16;
  localparam int DEF_STATUS_BASE = 32;

  // Registers are 64 bytes wide, so the index sits above a 6-bit byte offset.
  localparam int BYTE_OFS = 6;

endpackage

// File: rtl/bypass_reg_port_arbiter_rr_arbiter.sv
// Combinational round-robin picker: the search starts one past ptr and
// wraps, so the last winner has the lowest priority. grant is one-hot or zero.
module rr_arbiter
  import bypass_arb_pkg::*;
#(
  parameter int N     = DEF_N_REQ,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     grant
);

  logic w_found;

  // Walk offsets 1..N from the pointer and keep the first requester found.
  always_comb begin
    grant   = '0;
    w_found = 1'b0;
    for (int i = 1; i <= N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (!w_found && req[j] && (j == (int'(ptr) + i) % N)) begin
          grant[j] = 1'b1;
          w_found  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/bypass_reg_port_arbiter.sv
// Shares the single register-file port among N_REQ requesters.
// Handshake: a request is accepted on the clock edge where req_valid[i] and
// req_ready[i] are both high; the requester keeps valid and payload stable
// until then. Each transaction is IDLE(grant) -> ISSUE -> WAIT -> CAPTURE,
// and rsp_valid[id] pulses for one cycle right after CAPTURE.
module bypass_reg_port_arbiter
  import bypass_arb_pkg::*;
#(
  parameter int N_REQ       = DEF_N_REQ,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int IDX_W       = DEF_IDX_W,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int STATUS_BASE = DEF_STATUS_BASE
) (
  input  logic                           user_clk,
  input  logic                           user_reset,
  input  logic [N_REQ-1:0]               req_valid,
  output logic [N_REQ-1:0]               req_ready,
  input  logic [N_REQ-1:0]               req_we,
  input  logic [N_REQ-1:0][IDX_W-1:0]    req_idx,
  input  logic [N_REQ-1:0][DATA_W-1:0]   req_wdata,
  output logic [N_REQ-1:0]               rsp_valid,
  output logic                           rsp_we,
  output logic                           rsp_err,
  output logic [DATA_W-1:0]              rsp_rdata,
  output logic                           bram_en_a,
  output logic                           bram_we_a,
  output logic [ADDR_W-1:0]              bram_addr_a,
  output logic [DATA_W-1:0]              bram_wrdata_a,
  input  logic [DATA_W-1:0]              bram_rddata_a,
  output logic                           busy
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  arb_state_t              r_state;
  arb_state_t              w_next_state;
  logic [N_REQ-1:0]        w_grant;
  logic [PTR_W-1:0]        w_grant_id;
  logic                    w_accept;
  logic                    w_sel_we;
  logic [IDX_W-1:0]        w_sel_idx;
  logic [DATA_W-1:0]       w_sel_wdata;
  logic                    w_illegal;

  logic [PTR_W-1:0]        r_ptr;
  logic [PTR_W-1:0]        r_id;
  logic                    r_we;
  logic [IDX_W-1:0]        r_idx;
  logic [DATA_W-1:0]       r_wdata;
  logic [N_REQ-1:0]        r_rsp_valid;
  logic                    r_rsp_we;
  logic                    r_rsp_err;
  logic [DATA_W-1:0]       r_rsp_rdata;

  rr_arbiter #(.N(N_REQ), .PTR_W(PTR_W)) u_rr (
    .req   (req_valid),
    .ptr   (r_ptr),
    .grant (w_grant)
  );

  assign w_accept  = (r_state == ST_IDLE) && (|req_valid);
  // Writes into the read-only status range still take the full four cycles
  // but never reach the port.
  assign w_illegal = r_we && (32'(r_idx) >= 32'(STATUS_BASE));

  // Encode the one-hot grant and mux the winner's payload.
  always_comb begin
    w_grant_id  = '0;
    w_sel_we    = 1'b0;
    w_sel_idx   = '0;
    w_sel_wdata = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_grant[i]) begin
        w_grant_id  = PTR_W'(i);
        w_sel_we    = req_we[i];
        w_sel_idx   = req_idx[i];
        w_sel_wdata = req_wdata[i];
      end
    end
  end

  // State register.
  always_ff @(posedge user_clk) begin
    if (user_reset) r_state <= ST_IDLE;
    else            r_state <= w_next_state;
  end

  // Next state: leave IDLE on any request, then step unconditionally.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:    if (|req_valid) w_next_state = ST_ISSUE;
      ST_ISSUE:   w_next_state = ST_WAIT;
      ST_WAIT:    w_next_state = ST_CAPTURE;
      ST_CAPTURE: w_next_state = ST_IDLE;
      default:    w_next_state = ST_IDLE;
    endcase
  end

  // State-decoded outputs: ready only while idle, port strobe only in ISSUE.
  always_comb begin
    req_ready = '0;
    bram_en_a = 1'b0;
    bram_we_a = 1'b0;
    busy      = (r_state != ST_IDLE);
    case (r_state)
      ST_IDLE: req_ready = w_grant;
      ST_ISSUE: begin
        bram_en_a = !w_illegal;
        bram_we_a = r_we && !w_illegal;
      end
      default: ;
    endcase
  end

  // Latch the winning request and advance the round-robin pointer.
  always_ff @(posedge user_clk) begin
    if (user_reset) begin
      r_ptr   <= PTR_W'(N_REQ - 1);
      r_id    <= '0;
      r_we    <= 1'b0;
      r_idx   <= '0;
      r_wdata <= '0;
    end else if (w_accept) begin
      r_ptr   <= w_grant_id;
      r_id    <= w_grant_id;
      r_we    <= w_sel_we;
      r_idx   <= w_sel_idx;
      r_wdata <= w_sel_wdata;
    end
  end

  // Capture the response at the end of CAPTURE; the valid pulse lasts one cycle.
  always_ff @(posedge user_clk) begin
    if (user_reset) begin
      r_rsp_valid <= '0;
      r_rsp_we    <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
    end else if (r_state == ST_CAPTURE) begin
      r_rsp_valid <= N_REQ'(1) << r_id;
      r_rsp_we    <= r_we;
      r_rsp_err   <= w_illegal;
      r_rsp_rdata <= r_we ? '0 : bram_rddata_a;
    end else begin
      r_rsp_valid <= '0;
    end
  end

  assign bram_addr_a   = ADDR_W'({r_idx, {BYTE_OFS{1'b0}}});
  assign bram_wrdata_a = r_wdata;
  assign rsp_valid     = r_rsp_valid;
  assign rsp_we        = r_rsp_we;
  assign rsp_err       = r_rsp_err;
  assign rsp_rdata     = r_rsp_rdata;

endmodule

// File: tb/tb_bypass_reg_port_arbiter.sv
// Bench for bypass_reg_port_arbiter: directed scenarios followed by random
// traffic, checked against a transaction-level model of the arbiter.
module tb_bypass_reg_port_arbiter;
  import bypass_arb_pkg::*;

  localparam int N  = 3;
  localparam int DW = 512;
  localparam int IW = 6;
  localparam int AW = 16;
  localparam int SB = 32;

  // ---------------- clock / reset ----------------
  logic user_clk = 1'b0;
  logic user_reset;
  always #5 user_clk = ~user_clk;

  logic [N-1:0]          req_valid, req_ready, req_we, rsp_valid;
  logic [N-1:0][IW-1:0]  req_idx;
  logic [N-1:0][DW-1:0]  req_wdata;
  logic                  rsp_we, rsp_err, bram_en_a, bram_we_a, busy;
  logic [DW-1:0]         rsp_rdata, bram_wrdata_a, bram_rddata_a;
  logic [AW-1:0]         bram_addr_a;

  bypass_reg_port_arbiter #(.N_REQ(N), .DATA_W(DW), .IDX_W(IW), .ADDR_W(AW),
                            .STATUS_BASE(SB)) dut (
    .user_clk(user_clk), .user_reset(user_reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_idx(req_idx), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_we(rsp_we), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .bram_en_a(bram_en_a), .bram_we_a(bram_we_a), .bram_addr_a(bram_addr_a),
    .bram_wrdata_a(bram_wrdata_a), .bram_rddata_a(bram_rddata_a), .busy(busy)
  );

  function automatic logic [DW-1:0] status_val(input int idx);
    return {16{32'h5A00_0000 | 32'(idx)}};
  endfunction

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d;
    for (int k = 0; k < 16; k++) d[k*32 +: 32] = $urandom;
    return d;
  endfunction

  // ---------------- register-file slave ----------------
  // One-cycle read latency; status range returns fixed contents.
  logic [DW-1:0] mem [64];
  logic [DW-1:0] slave_rd;
  assign bram_rddata_a = slave_rd;
  always @(posedge user_clk) begin
    if (user_reset) begin
      for (int k = 0; k < 64; k++) mem[k] <= '0;
      slave_rd <= '0;
    end else if (bram_en_a) begin
      if (bram_we_a) mem[bram_addr_a[11:6]] <= bram_wrdata_a;
      slave_rd <= (int'(bram_addr_a[11:6]) >= SB) ? status_val(int'(bram_addr_a[11:6]))
                                                   : mem[bram_addr_a[11:6]];
    end
  end

  // ---------------- scoreboard / model state ----------------
  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;
  logic [DW-1:0] exp_q[$];
  int   due_q[$];
  int   id_q[$];
  logic we_q[$];
  logic err_q[$];
  logic [DW-1:0] ref_regs [64];
  int   m_ptr, m_free, m_en_cyc;
  logic m_en_we;
  logic [AW-1:0] m_en_addr;
  logic [DW-1:0] m_en_wd;

  logic [N-1:0]         pend_v, pend_we;
  logic [N-1:0][IW-1:0] pend_idx;
  logic [N-1:0][DW-1:0] pend_wd;
  logic tb_rst;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  // Round-robin by its definition: lowest valid id above the last winner,
  // otherwise the lowest valid id overall.
  function automatic int rr_pick(input int ptr, input logic [N-1:0] v);
    for (int j = 0; j < N; j++) if (v[j] && j > ptr) return j;
    for (int j = 0; j < N; j++) if (v[j]) return j;
    return -1;
  endfunction

  task automatic model_reset();
    exp_q.delete(); due_q.delete(); id_q.delete(); we_q.delete(); err_q.delete();
    m_ptr    = N - 1;
    m_free   = cyc + 1;
    m_en_cyc = -1;
    for (int k = 0; k < 64; k++) ref_regs[k] = (k >= SB) ? status_val(k) : '0;
  endtask

  // Called once per cycle on the falling edge.
  task automatic monitor();
    logic [N-1:0] exp_ready, exp_rv;
    logic exp_en, due, we, err;
    int g, idx;
    exp_ready = '0;
    g = -1;
    if (!user_reset && cyc >= m_free && req_valid != '0) begin
      g = rr_pick(m_ptr, req_valid);
      exp_ready[g] = 1'b1;
    end
    check("ready", req_ready, exp_ready);
    check("busy", busy, (cyc > m_free - 4) && (cyc < m_free));
    exp_en = (cyc == m_en_cyc);
    check("bram_en", bram_en_a, exp_en);
    check("bram_we", bram_we_a, exp_en && m_en_we);
    if (exp_en) begin
      check("bram_addr", bram_addr_a, m_en_addr);
      if (m_en_we) check("bram_wrdata", bram_wrdata_a, m_en_wd);
    end
    exp_rv = '0;
    due = (due_q.size() > 0) && (due_q[0] == cyc);
    if (due) exp_rv[id_q[0]] = 1'b1;
    check("rsp_valid", rsp_valid, exp_rv);
    if (due) begin
      check("rsp_we", rsp_we, we_q[0]);
      check("rsp_err", rsp_err, err_q[0]);
      check("rsp_rdata", rsp_rdata, exp_q[0]);
      void'(exp_q.pop_front()); void'(due_q.pop_front()); void'(id_q.pop_front());
      void'(we_q.pop_front()); void'(err_q.pop_front());
    end
    // Requesters drop their request once it is accepted.
    for (int i = 0; i < N; i++) if (req_ready[i]) pend_v[i] = 1'b0;
    if (g >= 0) begin
      we  = req_we[g];
      idx = int'(req_idx[g]);
      err = we && (idx >= SB);
      exp_q.push_back(we ? '0 : ref_regs[idx]);
      due_q.push_back(cyc + 4);
      id_q.push_back(g);
      we_q.push_back(we);
      err_q.push_back(err);
      if (we && !err) ref_regs[idx] = req_wdata[g];
      if (!err) begin
        m_en_cyc  = cyc + 1;
        m_en_we   = we;
        m_en_addr = AW'(idx * 64);
        m_en_wd   = req_wdata[g];
      end
      m_ptr  = g;
      m_free = cyc + 4;
    end
    if (user_reset) model_reset();
  endtask

  // ---------------- driver tasks ----------------
  task automatic apply();
    user_reset = tb_rst;
    req_valid  = tb_rst ? '0 : pend_v;
    req_we     = pend_we;
    req_idx    = pend_idx;
    req_wdata  = pend_wd;
  endtask

  task automatic step();
    @(posedge user_clk);
    #1;
    apply();
    @(negedge user_clk);
    cyc++;
    monitor();
  endtask

  task automatic post(input int id, input logic we, input int idx, input logic [DW-1:0] wd);
    pend_v[id]   = 1'b1;
    pend_we[id]  = we;
    pend_idx[id] = IW'(idx);
    pend_wd[id]  = wd;
  endtask

  task automatic wait_accept(input int id);
    int k = 0;
    while (pend_v[id] && k < 40) begin step(); k++; end
    check("accept_wait", pend_v[id], 1'b0);
  endtask

  task automatic drain();
    int k = 0;
    while ((due_q.size() > 0 || pend_v != '0) && k < 80) begin step(); k++; end
    check("drain", 32'(due_q.size()), 0);
  endtask

  // ---------------- stimulus ----------------
  int last_en;
  logic [DW-1:0] pat5;

  initial begin
    pat5     = {16{32'hA5A5_0005}};
    pend_v   = '0; pend_we = '0; pend_idx = '0; pend_wd = '0;
    tb_rst   = 1'b1;
    apply();
    repeat (3) @(posedge user_clk);
    @(negedge user_clk);
    model_reset();
    check("rst_ready", req_ready, '0);
    check("rst_rsp_valid", rsp_valid, '0);
    check("rst_rsp_we", rsp_we, 1'b0);
    check("rst_rsp_err", rsp_err, 1'b0);
    check("rst_rsp_rdata", rsp_rdata, '0);
    check("rst_en", bram_en_a, 1'b0);
    check("rst_we", bram_we_a, 1'b0);
    check("rst_addr", bram_addr_a, '0);
    check("rst_wrdata", bram_wrdata_a, '0);
    check("rst_busy", busy, 1'b0);
    tb_rst = 1'b0;

    // Write idx 5 from req0 while req1 also asks: req0 must win first.
    post(1, 1'b0, 2, '0);
    post(0, 1'b1, 5, pat5);
    wait_accept(0);
    check("first_grant", req_ready, 3'b001);
    step();
    check("wr_en", bram_en_a, 1'b1);
    check("wr_we", bram_we_a, 1'b1);
    check("wr_addr", bram_addr_a, 16'h0140);
    repeat (3) step();
    check("wr_rsp_valid", rsp_valid[0], 1'b1);
    check("wr_rsp_we", rsp_we, 1'b1);
    check("wr_rsp_err", rsp_err, 1'b0);
    drain();

    // Read back idx 5.
    post(0, 1'b0, 5, '0);
    wait_accept(0);
    repeat (4) step();
    check("rd5_valid", rsp_valid[0], 1'b1);
    check("rd5_data", rsp_rdata, pat5);
    drain();

    // Contention: req0 and req1 always valid with reads.
    last_en = -1;
    for (int t = 0; t < 32; t++) begin
      for (int i = 0; i < 2; i++) if (!pend_v[i]) post(i, 1'b0, $urandom_range(0, 63), '0);
      step();
      if (bram_en_a) begin
        if (last_en >= 0) check("en_spacing", 32'(cyc - last_en), 4);
        last_en = cyc;
      end
    end
    drain();

    // Illegal write to a status register.
    post(1, 1'b1, 40, rand_data());
    wait_accept(1);
    for (int t = 0; t < 3; t++) begin step(); check("illegal_en", bram_en_a, 1'b0); end
    step();
    check("illegal_rsp_valid", rsp_valid, 3'b010);
    check("illegal_rsp_err", rsp_err, 1'b1);
    drain();

    // Read of a status register.
    post(0, 1'b0, 33, '0);
    wait_accept(0);
    repeat (4) step();
    check("status_err", rsp_err, 1'b0);
    check("status_data", rsp_rdata, ref_regs[33]);
    drain();

    // Reset while the transaction sits in WAIT.
    post(0, 1'b0, 7, '0);
    wait_accept(0);
    step();
    tb_rst = 1'b1;
    step();
    tb_rst = 1'b0;
    step();
    check("midrst_busy", busy, 1'b0);
    check("midrst_en", bram_en_a, 1'b0);
    check("midrst_rsp", rsp_valid, '0);
    repeat (4) step();
    post(1, 1'b1, 9, rand_data());
    drain();
    post(1, 1'b0, 9, '0);
    drain();

    // Random traffic from all requesters.
    for (int t = 0; t < 400; t++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend_v[i] && $urandom_range(0, 2) == 0)
          post(i, 1'(($urandom_range(0, 2)) == 0), $urandom_range(0, 63), rand_data());
      end
      step();
    end
    drain();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
